// File: rtl/pcpi_arbiter.sv
// -----------------------------------------------------------------------------
// pcpi_arbiter
//
// Shares one picorv32 PCPI request among NUM_COP coprocessors. The request is
// broadcast to every enabled slot; the first slot to answer with wait or ready
// wins (lowest index on a tie). The losers are gated off and the winner's
// result is registered back to the CPU. If nobody answers within TIMEOUT
// cycles, a one-cycle pcpi_illegal pulse is returned instead.
//
// Ports
//   clk, reset            clock, asynchronous active-high reset
//   cop_enable            per-slot enable mask, sampled only while idle
//   pcpi_valid            CPU request valid
//   cop_valid             per-slot gated request valid
//   cop_wr/rd/wait/ready  per-slot coprocessor response (rd packed DATA_W/slot)
//   pcpi_wr/rd            registered write-back flag and result to the CPU
//   pcpi_wait             combinational wait to the CPU
//   pcpi_ready            one-cycle done pulse
//   pcpi_illegal          one-cycle pulse when nothing claimed the request
//   grant                 current or last granted slot
//   collision             sticky: several slots answered in the same cycle
//
// Optional feature (macro PCPI_ARBITER_STATS_EN):
//   stat_clear            clears the busy counters (wins over increment)
//   stat_busy             per-slot saturating 16-bit busy-cycle counters
// -----------------------------------------------------------------------------
module pcpi_arbiter #(
    parameter int  NUM_COP = 4,
    parameter int  TIMEOUT = 16,
    parameter int  DATA_W  = 32,
    localparam int GW      = (NUM_COP > 1) ? $clog2(NUM_COP) : 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_COP-1:0]        cop_enable,
    input  logic                      pcpi_valid,
    output logic [NUM_COP-1:0]        cop_valid,
    input  logic [NUM_COP-1:0]        cop_wr,
    input  logic [NUM_COP*DATA_W-1:0] cop_rd,
    input  logic [NUM_COP-1:0]        cop_wait,
    input  logic [NUM_COP-1:0]        cop_ready,
    output logic                      pcpi_wr,
    output logic [DATA_W-1:0]         pcpi_rd,
    output logic                      pcpi_wait,
    output logic                      pcpi_ready,
    output logic                      pcpi_illegal,
    output logic [GW-1:0]             grant,
    output logic                      collision
`ifdef PCPI_ARBITER_STATS_EN
    ,
    input  logic                      stat_clear,
    output logic [NUM_COP*16-1:0]     stat_busy
`endif
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CLAIM = 3'd1;
    localparam logic [2:0] S_BUSY  = 3'd2;
    localparam logic [2:0] S_RESP  = 3'd3;
    localparam logic [2:0] S_DRAIN = 3'd4;

    logic [2:0]         state_q, state_d;
    logic [NUM_COP-1:0] en_q, en_d;
    logic [7:0]         cnt_q, cnt_d;
    logic [GW-1:0]      grant_q, grant_d;
    logic               collision_q, collision_d;
    logic               wr_q, wr_d;
    logic [DATA_W-1:0]  rd_q, rd_d;
    logic               illegal_q, illegal_d;

    logic [NUM_COP-1:0] ans;
    logic [GW-1:0]      win_idx;
    logic               win_seen;
    logic               multi;
    logic [GW-1:0]      sel_idx;
    logic               sel_ready;
    logic               sel_wr;
    logic [DATA_W-1:0]  sel_rd;

    // Winner selection and result mux. In CLAIM the candidate is the lowest
    // answering slot; in BUSY only the granted slot is looked at, so a stray
    // ready from a loser can never complete the request.
    always_comb begin
        ans      = (cop_wait | cop_ready) & en_q;
        win_idx  = '0;
        win_seen = 1'b0;
        multi    = 1'b0;
        for (int k = 0; k < NUM_COP; k++) begin
            if (ans[k]) begin
                if (win_seen) multi = 1'b1;
                else          win_idx = GW'(k);
                win_seen = 1'b1;
            end
        end
        sel_idx   = (state_q == S_CLAIM) ? win_idx : grant_q;
        sel_ready = 1'b0;
        sel_wr    = 1'b0;
        sel_rd    = '0;
        for (int k = 0; k < NUM_COP; k++) begin
            if (GW'(k) == sel_idx) begin
                sel_ready = cop_ready[k];
                sel_wr    = cop_wr[k];
                sel_rd    = cop_rd[k*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        en_d        = en_q;
        cnt_d       = cnt_q;
        grant_d     = grant_q;
        collision_d = collision_q;
        wr_d        = wr_q;
        rd_d        = rd_q;
        illegal_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                en_d = cop_enable;
                if (pcpi_valid) begin
                    state_d = S_CLAIM;
                    cnt_d   = '0;
                end
            end
            S_CLAIM: begin
                // A dropped request wins over any answer seen this cycle.
                if (!pcpi_valid) begin
                    state_d = S_IDLE;
                end else if (win_seen) begin
                    grant_d = win_idx;
                    if (multi) collision_d = 1'b1;
                    if (sel_ready) begin
                        wr_d    = sel_wr;
                        rd_d    = sel_rd;
                        state_d = S_RESP;
                    end else begin
                        state_d = S_BUSY;
                    end
                end else if (cnt_q == 8'(TIMEOUT - 1)) begin
                    illegal_d = 1'b1;
                    state_d   = S_DRAIN;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_BUSY: begin
                if (!pcpi_valid) begin
                    state_d = S_IDLE;
                end else if (sel_ready) begin
                    wr_d    = sel_wr;
                    rd_d    = sel_rd;
                    state_d = S_RESP;
                end
            end
            S_RESP:  state_d = S_DRAIN;
            S_DRAIN: if (!pcpi_valid) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            en_q        <= '0;
            cnt_q       <= '0;
            grant_q     <= '0;
            collision_q <= 1'b0;
            wr_q        <= 1'b0;
            rd_q        <= '0;
            illegal_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            en_q        <= en_d;
            cnt_q       <= cnt_d;
            grant_q     <= grant_d;
            collision_q <= collision_d;
            wr_q        <= wr_d;
            rd_q        <= rd_d;
            illegal_q   <= illegal_d;
        end
    end

    always_comb begin
        cop_valid = '0;
        if (state_q == S_CLAIM)
            cop_valid = {NUM_COP{pcpi_valid}} & en_q;
        else if (state_q == S_BUSY)
            for (int k = 0; k < NUM_COP; k++)
                cop_valid[k] = pcpi_valid && (GW'(k) == grant_q);
    end

    // Combinational so a claim reaches the CPU in the cycle it is made.
    assign pcpi_wait    = ((state_q == S_CLAIM) && |(cop_wait & en_q)) || (state_q == S_BUSY);
    assign pcpi_ready   = (state_q == S_RESP);
    assign pcpi_illegal = illegal_q;
    assign pcpi_wr      = wr_q;
    assign pcpi_rd      = rd_q;
    assign grant        = grant_q;
    assign collision    = collision_q;

`ifdef PCPI_ARBITER_STATS_EN
    logic [NUM_COP-1:0][15:0] busy_q, busy_d;

    always_comb begin
        busy_d = busy_q;
        for (int k = 0; k < NUM_COP; k++) begin
            if (stat_clear)
                busy_d[k] = '0;
            else if ((state_q == S_BUSY || state_q == S_RESP) && grant_q == GW'(k)
                     && busy_q[k] != 16'hFFFF)
                busy_d[k] = busy_q[k] + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) busy_q <= '0;
        else       busy_q <= busy_d;
    end

    assign stat_busy = busy_q;
`endif

endmodule

// File: tb/tb_pcpi_arbiter.sv
module tb_pcpi_arbiter;
    localparam int NC   = 4;
    localparam int TO   = 16;
    localparam int DW   = 32;
    localparam int MAXC = 64;

    logic          clk = 1'b0;
    logic          reset;
    logic [NC-1:0] cop_enable;
    logic          pcpi_valid;
    logic [NC-1:0] cop_valid;
    logic [NC-1:0] cop_wr;
    logic [NC*DW-1:0] cop_rd;
    logic [NC-1:0] cop_wait;
    logic [NC-1:0] cop_ready;
    logic          pcpi_wr;
    logic [DW-1:0] pcpi_rd;
    logic          pcpi_wait;
    logic          pcpi_ready;
    logic          pcpi_illegal;
    logic [1:0]    grant;
    logic          collision;
`ifdef PCPI_ARBITER_STATS_EN
    logic          stat_clear;
    logic [NC*16-1:0] stat_busy;
`endif

    pcpi_arbiter #(.NUM_COP(NC), .TIMEOUT(TO), .DATA_W(DW)) dut (
        .clk(clk), .reset(reset), .cop_enable(cop_enable), .pcpi_valid(pcpi_valid),
        .cop_valid(cop_valid), .cop_wr(cop_wr), .cop_rd(cop_rd), .cop_wait(cop_wait),
        .cop_ready(cop_ready), .pcpi_wr(pcpi_wr), .pcpi_rd(pcpi_rd), .pcpi_wait(pcpi_wait),
        .pcpi_ready(pcpi_ready), .pcpi_illegal(pcpi_illegal), .grant(grant),
        .collision(collision)
`ifdef PCPI_ARBITER_STATS_EN
        , .stat_clear(stat_clear), .stat_busy(stat_busy)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Slot behaviour script: styp 0 = ready pulse at sa, 1 = wait from sa then
    // ready at sr, 2 = silent. Cycle 0 is the first CLAIM cycle.
    int          styp[NC];
    int          sa[NC];
    int          sr[NC];
    logic [31:0] srd[NC];
    logic        swr[NC];
    bit          scramble;

    int          obs_end, obs_rdy_cnt, obs_ill_cnt, obs_rdy_cyc, obs_ill_cyc;
    logic        obs_wait[MAXC];
    logic [3:0]  obs_cv[MAXC];
    logic [31:0] obs_rd;
    logic        obs_wr;
    logic [1:0]  obs_grant;
    logic        obs_col;

    // Transaction-level reference: first answer time, winner, end cycle.
    int          m_T, m_w, m_end;
    bit          m_claimed, m_multi;
    logic [31:0] m_rd;
    logic        m_wr;
    logic [1:0]  m_grant;
    logic        m_col;

    function automatic void silence();
        for (int k = 0; k < NC; k++) begin
            styp[k] = 2; sa[k] = 0; sr[k] = 0; srd[k] = '0; swr[k] = 1'b0;
        end
        scramble = 1'b0;
    endfunction

    function automatic void model_txn(input logic [3:0] en);
        int cnt;
        m_T = -1; m_w = 0; cnt = 0;
        for (int t = 0; t < TO && m_T < 0; t++)
            for (int k = NC - 1; k >= 0; k--)
                if (en[k] && styp[k] != 2 && sa[k] == t) begin
                    m_T = t; m_w = k; cnt++;
                end
        m_claimed = (m_T >= 0);
        m_multi   = (cnt > 1);
        if (m_claimed) begin
            m_end   = (styp[m_w] == 0) ? m_T + 1 : sr[m_w] + 1;
            m_rd    = srd[m_w];
            m_wr    = swr[m_w];
            m_grant = 2'(m_w);
            if (m_multi) m_col = 1'b1;
        end else begin
            m_end = TO;
        end
    endfunction

    function automatic logic exp_wait(input int t, input logic [3:0] en);
        logic any;
        any = 1'b0;
        if (!m_claimed || t < m_T || t >= m_end) return 1'b0;
        if (t > m_T) return 1'b1;
        for (int k = 0; k < NC; k++)
            if (en[k] && styp[k] == 1 && sa[k] == m_T) any = 1'b1;
        return any;
    endfunction

    function automatic logic [3:0] exp_cv(input int t, input logic [3:0] en);
        if (!m_claimed) return (t < TO) ? en : 4'h0;
        if (t <= m_T) return en;
        if (t < m_end) return 4'(1 << m_w);
        return 4'h0;
    endfunction

    task automatic drive_slots(input int t);
        for (int k = 0; k < NC; k++) begin
            cop_wait[k]  = 1'b0;
            cop_ready[k] = 1'b0;
            if (styp[k] == 0) begin
                cop_ready[k] = (t == sa[k]);
            end else if (styp[k] == 1) begin
                cop_wait[k]  = (t >= sa[k] && t < sr[k]);
                cop_ready[k] = (t == sr[k]);
            end
            cop_wr[k] = swr[k];
            cop_rd[k*DW +: DW] = srd[k];
        end
        if (scramble) cop_enable = 4'($urandom);
    endtask

    task automatic count_pulses();
        if (pcpi_ready === 1'b1) obs_rdy_cnt++;
        if (pcpi_illegal === 1'b1) obs_ill_cnt++;
    endtask

    // Issue one request and record what the DUT did; CPU drops valid 'hold'
    // cycles after the response.
    task automatic run_txn(input logic [3:0] en, input int hold);
        int e;
        e = -1;
        obs_rdy_cnt = 0; obs_ill_cnt = 0; obs_rdy_cyc = -1; obs_ill_cyc = -1;
        for (int i = 0; i < MAXC; i++) begin obs_wait[i] = 1'bx; obs_cv[i] = 'x; end
        cop_enable = en; pcpi_valid = 1'b1; cop_wait = '0; cop_ready = '0;
        @(posedge clk); #1;
        for (int t = 0; t < MAXC; t++) begin
            drive_slots(t);
            @(negedge clk);
            obs_wait[t] = pcpi_wait;
            obs_cv[t]   = cop_valid;
            if (pcpi_ready === 1'b1 && obs_rdy_cyc < 0) obs_rdy_cyc = t;
            if (pcpi_illegal === 1'b1 && obs_ill_cyc < 0) obs_ill_cyc = t;
            count_pulses();
            if (pcpi_ready === 1'b1 || pcpi_illegal === 1'b1) begin
                e = t; obs_rd = pcpi_rd; obs_wr = pcpi_wr;
                obs_grant = grant; obs_col = collision;
            end
            @(posedge clk); #1;
            if (e >= 0) break;
        end
        obs_end = e;
        cop_wait = '0; cop_ready = '0; cop_enable = en;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk); count_pulses(); @(posedge clk); #1;
        end
        pcpi_valid = 1'b0;
        repeat (2) begin
            @(negedge clk); count_pulses(); @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; cop_enable = '0; pcpi_valid = 1'b0; cop_wr = '0; cop_rd = '0;
        cop_wait = '0; cop_ready = '0;
`ifdef PCPI_ARBITER_STATS_EN
        stat_clear = 1'b0;
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({cop_valid, pcpi_wr, pcpi_rd, pcpi_wait, pcpi_ready, pcpi_illegal, grant, collision} !== 42'h0) begin
            errors++;
            $display("FAIL reset_outputs: got cv=%b wr=%b rd=%h wait=%b rdy=%b ill=%b g=%0d col=%b, want all 0",
                     cop_valid, pcpi_wr, pcpi_rd, pcpi_wait, pcpi_ready, pcpi_illegal, grant, collision);
        end
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({cop_valid, pcpi_wait, pcpi_ready, pcpi_illegal, collision} !== 8'h0) begin
            errors++;
            $display("FAIL idle_after_reset: got cv=%b wait=%b rdy=%b ill=%b col=%b, want 0",
                     cop_valid, pcpi_wait, pcpi_ready, pcpi_illegal, collision);
        end
        m_rd = '0; m_wr = 1'b0; m_grant = '0; m_col = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_single_cycle();
        silence();
        styp[1] = 0; sa[1] = 0; srd[1] = 32'h0000_00A5; swr[1] = 1'b1;
        model_txn(4'hF);
        run_txn(4'hF, 0);
        checks++;
        if (obs_rdy_cyc !== 1) begin errors++; $display("FAIL single_latency: ready at %0d, want 1", obs_rdy_cyc); end
        checks++;
        if (obs_rd !== 32'h0000_00A5 || obs_wr !== 1'b1 || obs_grant !== 2'd1) begin
            errors++;
            $display("FAIL single_data: rd=%h wr=%b g=%0d, want rd=000000a5 wr=1 g=1", obs_rd, obs_wr, obs_grant);
        end
        checks++;
        if (obs_rdy_cnt !== 1 || obs_ill_cnt !== 0) begin
            errors++; $display("FAIL single_pulse: ready pulses=%0d illegal=%0d, want 1/0", obs_rdy_cnt, obs_ill_cnt);
        end
    endtask

    task automatic test_multi_cycle();
        silence();
        styp[2] = 1; sa[2] = 0; sr[2] = 33; srd[2] = 32'hDEAD_BEEF; swr[2] = 1'b1;
        model_txn(4'hF);
        run_txn(4'hF, 1);
        checks++;
        if (obs_end !== 34 || obs_rd !== 32'hDEAD_BEEF || obs_grant !== 2'd2) begin
            errors++;
            $display("FAIL multi_result: end=%0d rd=%h g=%0d, want 34 deadbeef 2", obs_end, obs_rd, obs_grant);
        end
        for (int t = 0; t < 34; t++) begin
            checks++;
            if (obs_wait[t] !== 1'b1) begin errors++; $display("FAIL multi_wait: cycle %0d wait=%b, want 1", t, obs_wait[t]); end
        end
        for (int t = 1; t < 34; t++) begin
            checks++;
            if (obs_cv[t] !== 4'b0100) begin errors++; $display("FAIL multi_gate: cycle %0d cop_valid=%b, want 0100", t, obs_cv[t]); end
        end
        checks++;
        if (obs_rdy_cnt !== 1 || obs_ill_cnt !== 0) begin
            errors++; $display("FAIL multi_pulse: ready pulses=%0d illegal=%0d, want 1/0", obs_rdy_cnt, obs_ill_cnt);
        end
    endtask

    task automatic test_timeout();
        silence();
        styp[0] = 0; sa[0] = 3; srd[0] = 32'h5555_5555;
        model_txn(4'h0);
        run_txn(4'h0, 1);
        checks++;
        if (obs_ill_cyc !== 16 || obs_ill_cnt !== 1 || obs_rdy_cnt !== 0) begin
            errors++;
            $display("FAIL timeout_pulse: illegal at %0d x%0d ready x%0d, want 16 x1 x0", obs_ill_cyc, obs_ill_cnt, obs_rdy_cnt);
        end
        checks++;
        if (obs_rd !== m_rd || obs_grant !== m_grant) begin
            errors++; $display("FAIL timeout_hold: rd=%h g=%0d, want %h %0d", obs_rd, obs_grant, m_rd, m_grant);
        end
        silence();
        styp[3] = 0; sa[3] = 0; srd[3] = 32'hC0DE_0003; swr[3] = 1'b0;
        model_txn(4'hF);
        run_txn(4'hF, 0);
        checks++;
        if (obs_rdy_cyc !== 1 || obs_rd !== 32'hC0DE_0003) begin
            errors++; $display("FAIL timeout_recover: ready at %0d rd=%h, want 1 c0de0003", obs_rdy_cyc, obs_rd);
        end
    endtask

    task automatic test_enable_mask();
        silence();
        styp[0] = 1; sa[0] = 1; sr[0] = 4; srd[0] = 32'hAAAA_0000;
        styp[1] = 1; sa[1] = 1; sr[1] = 6; srd[1] = 32'hBBBB_1111; swr[1] = 1'b1;
        model_txn(4'b1110);
        run_txn(4'b1110, 0);
        checks++;
        if (obs_end !== 7 || obs_grant !== 2'd1 || obs_rd !== 32'hBBBB_1111 || obs_col !== 1'b0) begin
            errors++;
            $display("FAIL mask_result: end=%0d g=%0d rd=%h col=%b, want 7 1 bbbb1111 0", obs_end, obs_grant, obs_rd, obs_col);
        end
        for (int t = 0; t <= 7; t++) begin
            checks++;
            if (obs_cv[t][0] !== 1'b0) begin errors++; $display("FAIL mask_gate: cycle %0d cop_valid[0]=%b, want 0", t, obs_cv[t][0]); end
        end
    endtask

    task automatic test_abort();
        bit seen;
        silence();
        cop_enable = 4'hF; pcpi_valid = 1'b1; cop_wait = '0; cop_ready = '0;
        @(posedge clk); #1;
        for (int t = 0; t < 5; t++) begin cop_wait = 4'b0100; @(posedge clk); #1; end
        pcpi_valid = 1'b0; cop_wait = '0; cop_ready = 4'b0100; cop_wr = 4'hF;
        cop_rd[2*DW +: DW] = 32'h1234_5678;
        m_grant = 2'd2;
        @(negedge clk);
        checks++;
        if (cop_valid !== 4'b0000) begin errors++; $display("FAIL abort_gate: cop_valid=%b, want 0000", cop_valid); end
        @(posedge clk); #1 cop_ready = '0;
        @(negedge clk);
        checks++;
        if (pcpi_ready !== 1'b0 || pcpi_wait !== 1'b0 || cop_valid !== 4'b0) begin
            errors++; $display("FAIL abort_idle: rdy=%b wait=%b cv=%b, want 0 0 0000", pcpi_ready, pcpi_wait, cop_valid);
        end
        checks++;
        if (pcpi_rd !== m_rd || pcpi_wr !== m_wr || grant !== m_grant) begin
            errors++; $display("FAIL abort_hold: rd=%h wr=%b g=%0d, want %h %b %0d", pcpi_rd, pcpi_wr, grant, m_rd, m_wr, m_grant);
        end
        // Abort during CLAIM with nobody answering: no illegal afterwards.
        @(posedge clk); #1 cop_enable = 4'h0; pcpi_valid = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1 pcpi_valid = 1'b0;
        seen = 1'b0;
        for (int t = 0; t < 24; t++) begin
            @(negedge clk);
            if (pcpi_illegal !== 1'b0 || pcpi_ready !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen) begin errors++; $display("FAIL abort_claim: illegal/ready pulse seen=1, want 0"); end
        @(posedge clk); #1;
    endtask

    task automatic test_priority_collision();
        silence();
        styp[0] = 0; sa[0] = 2; srd[0] = 32'h1111_0000; swr[0] = 1'b1;
        styp[3] = 0; sa[3] = 2; srd[3] = 32'h3333_0000; swr[3] = 1'b0;
        model_txn(4'hF);
        run_txn(4'hF, 0);
        checks++;
        if (obs_end !== 3 || obs_grant !== 2'd0 || obs_rd !== 32'h1111_0000 || obs_wr !== 1'b1 || obs_col !== 1'b1) begin
            errors++;
            $display("FAIL prio_result: end=%0d g=%0d rd=%h wr=%b col=%b, want 3 0 11110000 1 1",
                     obs_end, obs_grant, obs_rd, obs_wr, obs_col);
        end
        for (int n = 0; n < 3; n++) begin
            int k;
            silence();
            k = $urandom_range(0, 3);
            styp[k] = 0; sa[k] = $urandom_range(0, 5); srd[k] = $urandom; swr[k] = 1'($urandom);
            model_txn(4'hF);
            run_txn(4'hF, 0);
            checks++;
            if (obs_col !== 1'b1 || obs_grant !== 2'(k) || obs_rd !== srd[k]) begin
                errors++;
                $display("FAIL prio_sticky: col=%b g=%0d rd=%h, want 1 %0d %h", obs_col, obs_grant, obs_rd, k, srd[k]);
            end
        end
    endtask

    task automatic test_reset_mid_busy();
        cop_enable = 4'hF; pcpi_valid = 1'b1; cop_wait = '0; cop_ready = '0;
        @(posedge clk); #1;
        for (int t = 0; t < 3; t++) begin cop_wait = 4'b0010; @(posedge clk); #1; end
        @(negedge clk);
        checks++;
        if (pcpi_wait !== 1'b1 || collision !== m_col) begin
            errors++; $display("FAIL busy_pre_reset: wait=%b col=%b, want 1 %b", pcpi_wait, collision, m_col);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({cop_valid, pcpi_wr, pcpi_rd, pcpi_wait, pcpi_ready, pcpi_illegal, grant, collision} !== 42'h0) begin
            errors++;
            $display("FAIL async_reset: cv=%b wr=%b rd=%h wait=%b rdy=%b ill=%b g=%0d col=%b, want all 0",
                     cop_valid, pcpi_wr, pcpi_rd, pcpi_wait, pcpi_ready, pcpi_illegal, grant, collision);
        end
        pcpi_valid = 1'b0; cop_wait = '0;
        @(posedge clk); #1 reset = 1'b0;
        m_rd = '0; m_wr = 1'b0; m_grant = '0; m_col = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        for (int n = 0; n < 40; n++) begin
            logic [3:0] en;
            int hold;
            en = 4'($urandom);
            for (int k = 0; k < NC; k++) begin
                styp[k] = $urandom_range(0, 2);
                sa[k]   = $urandom_range(0, 18);
                sr[k]   = sa[k] + $urandom_range(1, 30);
                srd[k]  = $urandom;
                swr[k]  = 1'($urandom);
            end
            scramble = ($urandom_range(0, 3) == 0);
            hold     = $urandom_range(0, 1);
            model_txn(en);
            run_txn(en, hold);
            checks++;
            if (obs_end !== m_end) begin
                errors++; $display("FAIL rand_end: txn %0d end=%0d, want %0d", n, obs_end, m_end);
            end
            checks++;
            if (obs_rdy_cnt !== (m_claimed ? 1 : 0) || obs_ill_cnt !== (m_claimed ? 0 : 1)) begin
                errors++; $display("FAIL rand_pulses: txn %0d ready x%0d illegal x%0d, claimed=%0d",
                                   n, obs_rdy_cnt, obs_ill_cnt, m_claimed);
            end
            checks++;
            if (obs_rd !== m_rd || obs_wr !== m_wr || obs_grant !== m_grant || obs_col !== m_col) begin
                errors++;
                $display("FAIL rand_result: txn %0d rd=%h wr=%b g=%0d col=%b, want %h %b %0d %b",
                         n, obs_rd, obs_wr, obs_grant, obs_col, m_rd, m_wr, m_grant, m_col);
            end
            if (obs_end == m_end) begin
                for (int t = 0; t <= m_end; t++) begin
                    checks++;
                    if (obs_wait[t] !== exp_wait(t, en) || obs_cv[t] !== exp_cv(t, en)) begin
                        errors++;
                        $display("FAIL rand_cycle: txn %0d cycle %0d wait=%b cv=%b, want %b %b",
                                 n, t, obs_wait[t], obs_cv[t], exp_wait(t, en), exp_cv(t, en));
                    end
                end
            end
        end
        scramble = 1'b0;
    endtask

`ifdef PCPI_ARBITER_STATS_EN
    task automatic test_stats();
        stat_clear = 1'b1;
        @(posedge clk); #1 stat_clear = 1'b0;
        @(negedge clk);
        checks++;
        if (stat_busy !== 64'h0) begin errors++; $display("FAIL stats_clear: %h, want 0", stat_busy); end
        @(posedge clk); #1;
        silence();
        styp[1] = 1; sa[1] = 0; sr[1] = 7; srd[1] = 32'h0BAD_F00D;
        model_txn(4'hF);
        run_txn(4'hF, 0);
        checks++;
        if (stat_busy !== 64'h0000_0000_0008_0000) begin
            errors++; $display("FAIL stats_count: %h, want 0000000000080000", stat_busy);
        end
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        silence();
        test_reset();
        test_single_cycle();
        test_multi_cycle();
        test_timeout();
        test_enable_mask();
        test_abort();
        test_priority_collision();
        test_reset_mid_busy();
        test_random();
`ifdef PCPI_ARBITER_STATS_EN
        test_stats();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
